// File: rtl/nioslab2_onchip_ram_pipelined_if.sv
// Avalon-MM pipelined slave bundle between a Nios II master and the on-chip RAM.
interface nioslab2_onchip_ram_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic [1:0]              response;

    modport master (
        output chipselect, read, write, address, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid, response
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata,
        output waitrequest, readdata, readdatavalid, response
    );
endinterface

// File: rtl/nioslab2_onchip_ram_pipelined.sv
// Byte-enabled on-chip RAM behind an Avalon-MM pipelined slave; reads return after READ_LATENCY (1|2) advancing cycles.
// Backpressure: waitrequest while clken is low or reset_req is high; the read pipeline freezes and readdatavalid is masked.
module nioslab2_onchip_ram_pipelined #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 15,
    parameter int    DEPTH        = 25000,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "niosLab2_onchip_ram_pipelined.hex"
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 reset_req_i,
    input  logic                                 clken_i,
    nioslab2_onchip_ram_pipelined_if.slave       bus,
    output logic [15:0]                          err_count_o
);
    localparam int                  NB        = DATA_WIDTH / 8;
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if ((DATA_WIDTH % 8 != 0) || (DEPTH < 1) || (DEPTH > 2**ADDR_WIDTH) ||
        (READ_LATENCY < 1) || (READ_LATENCY > 2)) begin : g_bad_params
        $error("illegal parameter set for RAM image %s", INIT_FILE);
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] ram_rd_q;
    logic [IDX_W-1:0]      idx;
    logic                  adv, acc, in_range, do_wr, do_rd, err_evt;

    logic                  s1_vld_q, s1_vld_d, s1_err_q, s1_err_d, s1_zero_q, s1_zero_d;
    logic [DATA_WIDTH-1:0] s1_rdata;
    logic [15:0]           err_q, err_d;

    assign bus.waitrequest = ~(clken_i & ~reset_req_i);
    assign adv      = clken_i & ~reset_req_i & ~reset_i;
    assign acc      = bus.chipselect & adv & ~bus.waitrequest;
    assign in_range = {1'b0, bus.address} < DEPTH_LIM;
    assign idx      = bus.address[IDX_W-1:0];
    assign do_wr    = acc & bus.write & in_range;
    // A simultaneous read+write keeps the write and drops the read.
    assign do_rd    = acc & bus.read & ~bus.write;
    assign err_evt  = acc & (bus.read | bus.write) & (~in_range | (bus.read & bus.write));

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.byteenable[b]) begin
                    mem_q[idx][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
        if (do_rd && in_range) begin
            ram_rd_q <= mem_q[idx];
        end
    end

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_err_d  = s1_err_q;
        s1_zero_d = s1_zero_q;
        err_d     = err_q;
        if (adv) begin
            s1_vld_d = do_rd;
            if (do_rd) begin
                s1_err_d  = ~in_range;
                s1_zero_d = ~in_range;
            end
        end
        if (err_evt && (err_q != 16'hFFFF)) begin
            err_d = err_q + 16'd1;
        end
    end

    // s1_zero_q forces readdata to zero after reset and for out-of-range reads.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_vld_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_zero_q <= 1'b1;
            err_q     <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_err_q  <= s1_err_d;
            s1_zero_q <= s1_zero_d;
            err_q     <= err_d;
        end
    end

    assign s1_rdata    = s1_zero_q ? '0 : ram_rd_q;
    assign err_count_o = err_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_vld_q, s2_vld_d, s2_err_q, s2_err_d;
        logic [DATA_WIDTH-1:0] s2_dat_q, s2_dat_d;

        always_comb begin
            s2_vld_d = s2_vld_q;
            s2_err_d = s2_err_q;
            s2_dat_d = s2_dat_q;
            if (adv) begin
                s2_vld_d = s1_vld_q;
                if (s1_vld_q) begin
                    s2_err_d = s1_err_q;
                    s2_dat_d = s1_rdata;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                s2_vld_q <= 1'b0;
                s2_err_q <= 1'b0;
                s2_dat_q <= '0;
            end else begin
                s2_vld_q <= s2_vld_d;
                s2_err_q <= s2_err_d;
                s2_dat_q <= s2_dat_d;
            end
        end

        assign bus.readdatavalid = s2_vld_q & adv;
        assign bus.readdata      = s2_dat_q;
        assign bus.response      = {s2_err_q, 1'b0};
    end else begin : g_lat1
        assign bus.readdatavalid = s1_vld_q & adv;
        assign bus.readdata      = s1_rdata;
        assign bus.response      = {s1_err_q, 1'b0};
    end
endmodule
